ram2_arbiter: RTL
=================

RAM2_ARBITER -- requirements
Module: ram2_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port if_req, input, 1, fetch request, held high until if_valid.
REQ-004 SHALL have port if_addr, input, 16, fetch word address, stable while if_req high.
REQ-005 SHALL have port instruction, output, 16, last fetched word, registered.
REQ-006 SHALL have port if_valid, output, 1, one-cycle pulse: instruction updated.
REQ-007 SHALL have port mem_rd / mem_wr, input, 1 each, data read / write request, held until mem_done.
REQ-008 SHALL have port mem_addr / mem_wdata, input, 16 each, data address / write data, stable while a request is high.
REQ-009 SHALL have port mem_rdata, output, 16, last read word, registered.
REQ-010 SHALL have port mem_done, output, 1, one-cycle pulse: data access complete.
REQ-011 SHALL have port RAM2OE / RAM2WE / RAM2EN, output, 1 each, SRAM strobes, active-low.
REQ-012 SHALL have port RAM2ADDR, output, 18, SRAM address, {2'b00, latched 16-bit address}.
REQ-013 SHALL have port RAM2DATA, inout, 16, SRAM data; driven only in write states, else Z.

Function
REQ-014 SHALL implement states IDLE, FETCH, DREAD, WSETUP, WPULSE, WHOLD.
REQ-015 SHALL, in IDLE, latch the granted address and set the next state by arbitration; without a request, SHALL stay IDLE.
REQ-016 SHALL mask if_req in any cycle where if_valid is high, and mask mem_rd/mem_wr in any cycle where mem_done is high.
REQ-017 SHALL grant data (mem_rd|mem_wr) over fetch, except when the previous grant was data and if_req is pending; fetch then wins (alternation, no fetch starvation).
REQ-018 SHALL treat mem_rd and mem_wr both high as a write; mem_rdata unchanged.
REQ-019 SHALL, in FETCH/DREAD, drive EN=0, OE=0, WE=1, DATA=Z, and capture RAM2DATA at the cycle end into instruction/mem_rdata; then go to IDLE.
REQ-020 SHALL sequence a write as WSETUP (EN=0, OE=1, WE=1, data driven), WPULSE (WE=0), WHOLD (WE=1, data still driven), then IDLE.
REQ-021 SHALL drive EN=1, OE=1, WE=1, DATA=Z in IDLE.
REQ-022 SHALL assert if_valid / mem_done during the IDLE cycle following FETCH / DREAD / WHOLD.
REQ-023 SHALL give latencies from the IDLE grant cycle N: read or fetch valid at N+2; write done at N+4.
REQ-024 SHALL complete a started transaction even if its request drops mid-operation; the result pulse is still issued.
REQ-025 SHALL never drive RAM2DATA while OE=0; WE=0 occurs only in WPULSE.

Reset
REQ-026 SHALL, when RST is high at a clock edge, enter IDLE from any state, including mid-write.
REQ-027 SHALL set on reset: instruction=16'h0800 (NOP), mem_rdata=0, if_valid=0, mem_done=0, last-grant=fetch, RAM2 strobes per REQ-021.
REQ-028 SHALL abort a reset mid-WPULSE with WE=1 the next cycle and no mem_done.

Verification
REQ-029 SHALL cover: only if_req, if_addr=0x0010, SRAM[0x10]=0x4C21 -> RAM2ADDR=0x00010, OE low 1 cycle, instruction=0x4C21, if_valid at N+2.
REQ-030 SHALL cover: mem_wr, addr=0x8000, wdata=0xBEEF -> WE low exactly 1 cycle with DATA=0xBEEF held across setup/pulse/hold, mem_done at N+4, then read returns 0xBEEF.
REQ-031 SHALL cover: if_req and mem_rd held continuously -> grants alternate data, fetch, data, fetch; neither starves.
REQ-032 SHALL cover: mem_rd and mem_wr high together -> write performed, mem_rdata unchanged.
REQ-033 SHALL cover: RST high during WPULSE -> next cycle IDLE, WE=1, DATA=Z, instruction=0x0800, no mem_done.
REQ-034 SHALL cover: request held one cycle past its pulse -> no duplicate transaction issued.

Source files
------------

// File: rtl/ram2_arbiter_if.sv
// CPU-side bus of the RAM2 arbiter: instruction-fetch port and data port.
// master = CPU side (issues requests), slave = arbiter side.
interface ram2_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] instruction;
  logic        if_valid;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  instruction, if_valid, mem_rdata, mem_done
  );

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    output instruction, if_valid, mem_rdata, mem_done
  );
endinterface

// File: rtl/ram2_arbiter.sv
// Shares one asynchronous SRAM (RAM2) between an instruction-fetch port and a
// data read/write port. Data normally wins arbitration; after a data grant a
// pending fetch wins, so neither side starves.
//
// state  | meaning
// IDLE   | strobes inactive, result pulse issued here, arbitration + address latch
// FETCH  | SRAM read for the fetch port, word captured into instruction
// DREAD  | SRAM read for the data port, word captured into mem_rdata
// WSETUP | chip enabled, write data driven, WE still high
// WPULSE | WE low for exactly one cycle
// WHOLD  | WE back high, data still driven so it holds past the WE rising edge
module ram2_arbiter (
  input  logic         CLK,
  input  logic         RST,
  ram2_arbiter_if.slave bus,
  output logic         RAM2OE,
  output logic         RAM2WE,
  output logic         RAM2EN,
  output logic [17:0]  RAM2ADDR,
  inout  wire  [15:0]  RAM2DATA
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DREAD  = 3'd2,
    WSETUP = 3'd3,
    WPULSE = 3'd4,
    WHOLD  = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] instr_q;
  logic [15:0] rdata_q;
  logic        if_valid_q;
  logic        mem_done_q;
  logic        last_data;
  logic        drive_data;
  logic        oe_q;
  logic        we_q;
  logic        en_q;

  // A request is ignored in the cycle its own completion pulse is visible,
  // so a master that drops its request on that pulse does not get a repeat.
  logic fetch_pending;
  logic data_pending;
  logic grant_data;

  assign fetch_pending = bus.if_req & ~if_valid_q;
  assign data_pending  = (bus.mem_rd | bus.mem_wr) & ~mem_done_q;
  assign grant_data    = data_pending & ~(last_data & fetch_pending);

  assign bus.instruction = instr_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.mem_rdata   = rdata_q;
  assign bus.mem_done    = mem_done_q;

  assign RAM2OE   = oe_q;
  assign RAM2WE   = we_q;
  assign RAM2EN   = en_q;
  assign RAM2ADDR = {2'b00, addr_q};
  assign RAM2DATA = drive_data ? wdata_q : 16'hzzzz;

  // Sequencer: arbitration, SRAM strobe generation and result capture, all registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      instr_q    <= 16'h0800;
      rdata_q    <= 16'h0000;
      if_valid_q <= 1'b0;
      mem_done_q <= 1'b0;
      last_data  <= 1'b0;
      drive_data <= 1'b0;
      oe_q       <= 1'b1;
      we_q       <= 1'b1;
      en_q       <= 1'b1;
    end else begin
      if_valid_q <= 1'b0;
      mem_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            addr_q    <= bus.mem_addr;
            last_data <= 1'b1;
            en_q      <= 1'b0;
            // Read and write both high is treated as a write.
            if (bus.mem_wr) begin
              wdata_q    <= bus.mem_wdata;
              drive_data <= 1'b1;
              state      <= WSETUP;
            end else begin
              oe_q  <= 1'b0;
              state <= DREAD;
            end
          end else if (fetch_pending) begin
            addr_q    <= bus.if_addr;
            last_data <= 1'b0;
            en_q      <= 1'b0;
            oe_q      <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          instr_q    <= RAM2DATA;
          if_valid_q <= 1'b1;
          en_q       <= 1'b1;
          oe_q       <= 1'b1;
          state      <= IDLE;
        end
        DREAD: begin
          rdata_q    <= RAM2DATA;
          mem_done_q <= 1'b1;
          en_q       <= 1'b1;
          oe_q       <= 1'b1;
          state      <= IDLE;
        end
        WSETUP: begin
          we_q  <= 1'b0;
          state <= WPULSE;
        end
        WPULSE: begin
          we_q  <= 1'b1;
          state <= WHOLD;
        end
        WHOLD: begin
          drive_data <= 1'b0;
          en_q       <= 1'b1;
          mem_done_q <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          drive_data <= 1'b0;
          oe_q       <= 1'b1;
          we_q       <= 1'b1;
          en_q       <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
